// File: rtl/delay_line_prog.sv
// Programmable multi-channel delay line on a circular buffer (one write port, one registered read port).
// Optional build macro DLY_PRIME_MASK_EN forces d_o to zero while the line is priming (vld_o low).
module delay_line_prog #(
    parameter  int WIDTH     = 8,
    parameter  int CHANNELS  = 3,
    parameter  int MAX_DELAY = 2200,
    localparam int DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [DW-1:0]             dly_i,
    input  logic [CHANNELS*WIDTH-1:0] d_i,
    output logic [CHANNELS*WIDTH-1:0] d_o,
    output logic                      vld_o,
    output logic [DW-1:0]             dly_o
);

    localparam int            DATA_W = CHANNELS * WIDTH;
    localparam int            AW     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [DW-1:0] MAX_D  = DW'(MAX_DELAY);
    localparam logic [DW-1:0] LAST_P = DW'(MAX_DELAY - 1);
    localparam logic [DW-1:0] ONE_D  = DW'(1);
    localparam logic [DW:0]   MAX_W  = (DW + 1)'(MAX_DELAY);

    logic [DATA_W-1:0] mem [0:MAX_DELAY-1];
    logic [DATA_W-1:0] ram_q;

    logic [DW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]     dly_q, dly_d;
    logic [DW-1:0]     fill_q, fill_d;
    logic              vld_q, vld_d;
    logic              zero_q, zero_d;
    logic              byp_sel_q, byp_sel_d;
    logic [DATA_W-1:0] byp_q, byp_d;

    logic [DW-1:0]     dc_s;
    logic [DW:0]       sum_s;
    logic [DW:0]       rd_full_s;
    logic [DW-1:0]     rd_addr_s;

    // Clamp the requested delay into 1..MAX_DELAY.
    always_comb begin
        dc_s = dly_i;
        if (dly_i == {DW{1'b0}}) begin
            dc_s = ONE_D;
        end else if (dly_i > MAX_D) begin
            dc_s = MAX_D;
        end else begin
            dc_s = dly_i;
        end
    end

    // Read address = wr_ptr - Dc + 1 modulo MAX_DELAY, without a divider.
    always_comb begin
        sum_s     = {1'b0, wr_ptr_q} + (DW + 1)'(1);
        rd_full_s = sum_s;
        if (sum_s >= {1'b0, dc_s}) begin
            rd_full_s = sum_s - {1'b0, dc_s};
        end else begin
            rd_full_s = sum_s + (MAX_W - {1'b0, dc_s});
        end
        rd_addr_s = rd_full_s[DW-1:0];
    end

    // Next-state logic for pointer, delay, fill level, valid and output select.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        dly_d     = dly_q;
        fill_d    = fill_q;
        vld_d     = vld_q;
        zero_d    = zero_q;
        byp_sel_d = byp_sel_q;
        byp_d     = byp_q;
        if (en_i) begin
            if (wr_ptr_q == LAST_P) begin
                wr_ptr_d = {DW{1'b0}};
            end else begin
                wr_ptr_d = wr_ptr_q + ONE_D;
            end
            // D=1 reads the sample being written, which the RAM returns old; bypass it.
            byp_d     = d_i;
            byp_sel_d = (dc_s == ONE_D);
            if (dc_s != dly_q) begin
                dly_d  = dc_s;
                fill_d = ONE_D;
                vld_d  = (dc_s == ONE_D);
            end else begin
                if (fill_q < dly_q) begin
                    fill_d = fill_q + ONE_D;
                end else begin
                    fill_d = fill_q;
                end
                vld_d = (fill_q >= (dly_q - ONE_D));
            end
`ifdef DLY_PRIME_MASK_EN
            zero_d = ~vld_d;
`else
            zero_d = 1'b0;
`endif
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Control registers with synchronous reset; reset wins over enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= {DW{1'b0}};
            dly_q     <= {DW{1'b0}};
            fill_q    <= {DW{1'b0}};
            vld_q     <= 1'b0;
            zero_q    <= 1'b1;
            byp_sel_q <= 1'b0;
            byp_q     <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            dly_q     <= dly_d;
            fill_q    <= fill_d;
            vld_q     <= vld_d;
            zero_q    <= zero_d;
            byp_sel_q <= byp_sel_d;
            byp_q     <= byp_d;
        end
    end

    // Buffer RAM: single write port and read-before-write registered read port.
    always_ff @(posedge clk_i) begin
        if (en_i && !rst_i) begin
            mem[AW'(wr_ptr_q)] <= d_i;
            ram_q              <= mem[AW'(rd_addr_s)];
        end
    end

    assign d_o   = zero_q ? {DATA_W{1'b0}} : (byp_sel_q ? byp_q : ram_q);
    assign vld_o = vld_q;
    assign dly_o = dly_q;

endmodule

// File: tb/tb_delay_line_prog.sv
// Scoreboard bench for delay_line_prog: a small 1-channel/MAX=16 instance and a 3-channel/MAX=2200 instance.
module tb_delay_line_prog;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [4:0]  dly_a, dlyo_a;
    logic [11:0] dly_b, dlyo_b;
    logic [7:0]  d_a, q_a;
    logic [23:0] d_b, q_b;
    logic        vld_a, vld_b;

    always #5 clk = ~clk;

    delay_line_prog #(.WIDTH(8), .CHANNELS(1), .MAX_DELAY(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en_a), .dly_i(dly_a),
        .d_i(d_a), .d_o(q_a), .vld_o(vld_a), .dly_o(dlyo_a)
    );

    delay_line_prog #(.WIDTH(8), .CHANNELS(3), .MAX_DELAY(2200)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en_b), .dly_i(dly_b),
        .d_i(d_b), .d_o(q_b), .vld_o(vld_b), .dly_o(dlyo_b)
    );

    typedef struct {
        logic [23:0] d;
        bit          dk;
        bit          vld;
        int          dly;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    string       ph       = "init";
    int          cnt      = 0;

    int          m_dly [2];
    int          m_n   [2];
    int          m_g   [2];
    bit          m_vld [2];
    bit          m_dk  [2];
    logic [23:0] m_d   [2];
    logic [23:0] hist  [2][8192];

`ifdef DLY_PRIME_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s_%s: got %0h expected %0h", ph, tag, obs, expv);
        end
    endtask

    // Reference model of one instance for the coming edge; pushes its expectation.
    task automatic model_step(input int u, input bit r, input bit e, input int di,
                              input logic [23:0] din, input int maxd);
        int   dc;
        exp_t x;
        if (r) begin
            m_dly[u] = 0; m_n[u] = 0; m_vld[u] = 1'b0;
            m_d[u] = 24'h0; m_dk[u] = 1'b1;
        end else if (e) begin
            dc = (di == 0) ? 1 : ((di > maxd) ? maxd : di);
            hist[u][m_g[u]] = din;
            if (dc != m_dly[u]) begin
                m_dly[u] = dc;
                m_n[u] = 0;
            end else begin
                m_n[u] = m_n[u] + 1;
            end
            m_vld[u] = (m_n[u] >= m_dly[u] - 1);
            if (m_vld[u]) begin
                m_d[u] = hist[u][m_g[u] - m_dly[u] + 1]; m_dk[u] = 1'b1;
            end else if (MASK) begin
                m_d[u] = 24'h0; m_dk[u] = 1'b1;
            end else begin
                m_dk[u] = 1'b0;
            end
            m_g[u] = m_g[u] + 1;
        end
        x.d = m_d[u]; x.dk = m_dk[u]; x.vld = m_vld[u]; x.dly = m_dly[u];
        sb.push_back(x);
    endtask

    task automatic cyc(input bit r, input bit ea, input bit eb, input int da, input int db);
        exp_t x;
        @(negedge clk);
        rst   = r;
        en_a  = ea;
        en_b  = eb;
        dly_a = 5'(da);
        dly_b = 12'(db);
        d_a   = 8'(cnt);
        d_b   = {8'(cnt * 3 + 7), 8'(cnt + 100), 8'(cnt)};
        cnt++;
        model_step(0, r, ea, int'(dly_a), {16'h0, d_a}, 16);
        model_step(1, r, eb, int'(dly_b), d_b, 2200);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_eq("a_dly", 32'(dlyo_a), 32'(x.dly));
        check_eq("a_vld", 32'(vld_a), 32'(x.vld));
        if (x.dk) check_eq("a_d", 32'(q_a), 32'(x.d[7:0]));
        x = sb.pop_front();
        check_eq("b_dly", 32'(dlyo_b), 32'(x.dly));
        check_eq("b_vld", 32'(vld_b), 32'(x.vld));
        if (x.dk) check_eq("b_d", 32'(q_b), 32'(x.d));
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_dly[u] = 0; m_n[u] = 0; m_g[u] = 0;
            m_vld[u] = 1'b0; m_dk[u] = 1'b0; m_d[u] = 24'h0;
        end
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
        dly_a = 5'd0; dly_b = 12'd0; d_a = 8'd0; d_b = 24'd0;

        ph = "rst";
        cyc(1'b1, 1'b1, 1'b1, 5, 2200);
        cyc(1'b1, 1'b0, 1'b0, 5, 2200);
        cyc(1'b0, 1'b0, 1'b0, 5, 2200);

        ph = "t1";
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 5, 2200);

        ph = "t2";
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 5, 2200);

        ph = "t3";
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 9, 2200);
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 9, 2200);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 5, 2200);

        ph = "t4";
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 0, 2200);
        for (int i = 0; i < 80; i++) cyc(1'b0, 1'b1, 1'b0, 31, 2200);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16, 2200);

        ph = "t5";
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 5, 2200);
        cyc(1'b1, 1'b1, 1'b0, 5, 2200);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 5, 2200);

        ph = "t6";
        for (int i = 0; i < 2260; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 16, 2200);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16, 4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
